// File: rtl/qa_drv_ooo_responder_pkg.sv
// qa_drv_ooo_rsp_pkg: shared types and helpers for the out-of-order read responder.
//   t_lfsr       16-bit latency-jitter LFSR state
//   lfsr_next()  one Galois step, polynomial x^16+x^14+x^13+x^11+1
//   rsp_data_of() response payload {~addr zero/trunc-extended, addr}
package qa_drv_ooo_rsp_pkg;
    typedef logic [15:0] t_lfsr;
    localparam t_lfsr LFSR_TAPS = 16'hB400;
    localparam int MAX_W = 128;

    function automatic t_lfsr lfsr_next(input t_lfsr s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Widths are passed in so the one function serves any parameterisation;
    // the caller truncates the MAX_W-wide result to its data width.
    function automatic logic [MAX_W-1:0] rsp_data_of(input logic [MAX_W-1:0] addr, input int aw, input int dw);
        logic [MAX_W-1:0] d;
        d = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < aw) d[i] = addr[i];
            else if (i < dw && i - aw < aw) d[i] = ~addr[i - aw];
        end
        return d;
    endfunction
endpackage

// File: rtl/qa_drv_ooo_responder_if.sv
// qa_drv_ooo_responder_if: request/response bundle between a driver and the responder.
//   req_en/reqTag/reqAddr            request from the driver (legal only while notFull)
//   notFull                          at least one free slot
//   rsp_en/rspTag/rspData            registered response, no back-pressure
//   nOutstanding                     registered occupied-slot count
//   master = driver side, slave = responder side
interface qa_drv_ooo_responder_if #(
    parameter int N_ENTRIES   = 32,
    parameter int N_ADDR_BITS = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_SLOTS     = 8
);
    localparam int TW = $clog2(N_ENTRIES);
    localparam int CW = $clog2(N_SLOTS) + 1;
    logic                   req_en;
    logic [TW-1:0]          reqTag;
    logic [N_ADDR_BITS-1:0] reqAddr;
    logic                   notFull;
    logic                   rsp_en;
    logic [TW-1:0]          rspTag;
    logic [N_DATA_BITS-1:0] rspData;
    logic [CW-1:0]          nOutstanding;
    modport master (output req_en, reqTag, reqAddr, input notFull, rsp_en, rspTag, rspData, nOutstanding);
    modport slave  (input req_en, reqTag, reqAddr, output notFull, rsp_en, rspTag, rspData, nOutstanding);
endinterface

// File: rtl/qa_drv_ooo_responder_arb.sv
// qa_drv_rr_arbiter: combinational round-robin arbiter.
//   i_req  request vector        i_ptr  last granted index (search starts at i_ptr+1)
//   o_gnt  one-hot grant         o_idx  granted index      o_any  any request present
module qa_drv_rr_arbiter #(
    parameter int N_REQ = 8,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);
    logic [IW-1:0] w_j;

    assign o_any = |i_req;

    // Scan from the far end back towards ptr+1 so the nearest requester wins;
    // k == N_REQ wraps to ptr itself, which therefore has lowest priority.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_j   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_j = i_ptr + IW'(k);
            if (i_req[w_j]) begin
                o_gnt = N_REQ'(1) << w_j;
                o_idx = w_j;
            end
        end
    end
endmodule

// File: rtl/qa_drv_ooo_responder.sv
// qa_drv_ooo_responder: out-of-order read responder with per-request pseudo-random latency.
//   clk     clock
//   resetb  asynchronous active-low reset (synchronous release expected)
//   bus     slave side of qa_drv_ooo_responder_if: tagged requests in, tagged responses out
module qa_drv_ooo_responder
    import qa_drv_ooo_rsp_pkg::*;
#(
    parameter int    N_ENTRIES    = 32,
    parameter int    N_DATA_BITS  = 64,
    parameter int    N_ADDR_BITS  = 32,
    parameter int    N_SLOTS      = 8,
    parameter int    MIN_LAT      = 4,
    parameter int    RND_LAT_BITS = 4,
    parameter t_lfsr LFSR_SEED    = 16'h1
) (
    input logic                   clk,
    input logic                   resetb,
    qa_drv_ooo_responder_if.slave bus
);
    localparam int TW  = $clog2(N_ENTRIES);
    localparam int SW  = $clog2(N_SLOTS);
    localparam int CW  = SW + 1;
    localparam int TMW = $clog2(MIN_LAT + 2**RND_LAT_BITS);
    localparam int RB  = (RND_LAT_BITS == 0) ? 1 : RND_LAT_BITS;

    logic [N_SLOTS-1:0]     r_valid;
    logic [TW-1:0]          r_tag   [N_SLOTS];
    logic [N_ADDR_BITS-1:0] r_addr  [N_SLOTS];
    logic [TMW-1:0]         r_timer [N_SLOTS];
    t_lfsr                  r_lfsr;
    logic [SW-1:0]          r_ptr;
    logic                   r_rsp_en;
    logic [TW-1:0]          r_rsp_tag;
    logic [N_DATA_BITS-1:0] r_rsp_data;
    logic [CW-1:0]          r_cnt;

    logic [N_SLOTS-1:0]     w_ready;
    logic [N_SLOTS-1:0]     w_gnt;
    logic [SW-1:0]          w_gnt_idx;
    logic                   w_gnt_any;
    logic [SW-1:0]          w_free_idx;
    logic [N_SLOTS-1:0]     w_free_oh;
    logic                   w_not_full;
    logic                   w_acc;
    logic                   w_dup;
    logic [RB-1:0]          w_rnd;
    logic [TMW-1:0]         w_timer_init;
    logic [N_DATA_BITS-1:0] w_gnt_data;

    // notFull looks only at registered valid, so a slot freed on a grant edge
    // becomes reusable one cycle later.
    assign w_not_full   = ~&r_valid;
    assign w_acc        = bus.req_en & w_not_full;
    assign w_free_oh    = N_SLOTS'(1) << w_free_idx;
    assign w_rnd        = (RND_LAT_BITS == 0) ? '0 : r_lfsr[RB-1:0];
    assign w_timer_init = TMW'(MIN_LAT - 1) + TMW'(w_rnd);
    assign w_gnt_data   = N_DATA_BITS'(rsp_data_of(MAX_W'(r_addr[w_gnt_idx]), N_ADDR_BITS, N_DATA_BITS));

    // Lowest-index free slot: descending scan lets the lowest index win.
    always_comb begin
        w_free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--)
            if (!r_valid[i]) w_free_idx = SW'(i);
    end

    always_comb begin
        w_dup   = 1'b0;
        w_ready = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_ready[i] = r_valid[i] && (r_timer[i] == '0);
            if (r_valid[i] && r_tag[i] == bus.reqTag) w_dup = 1'b1;
        end
    end

    qa_drv_rr_arbiter #(.N_REQ(N_SLOTS)) u_arb (
        .i_req (w_ready),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    // Slot payload and timers need no reset: they are only observed through valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SLOTS; i++)
            r_timer[i] <= (w_acc && w_free_idx == SW'(i)) ? w_timer_init :
                          (r_valid[i] && r_timer[i] != '0) ? r_timer[i] - TMW'(1) : r_timer[i];
        if (w_acc) begin
            r_tag[w_free_idx]  <= bus.reqTag;
            r_addr[w_free_idx] <= bus.reqAddr;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_valid    <= '0;
            r_lfsr     <= LFSR_SEED;
            r_ptr      <= '0;
            r_rsp_en   <= 1'b0;
            r_rsp_tag  <= '0;
            r_rsp_data <= '0;
            r_cnt      <= '0;
        end else begin
            // The freed and the loaded slot never coincide: the loaded one was invalid.
            r_valid  <= (r_valid & ~w_gnt) | (w_acc ? w_free_oh : '0);
            r_cnt    <= r_cnt + CW'(w_acc) - CW'(w_gnt_any);
            r_rsp_en <= w_gnt_any;
            if (w_acc) r_lfsr <= lfsr_next(r_lfsr);
            if (w_gnt_any) begin
                r_ptr      <= w_gnt_idx;
                r_rsp_tag  <= r_tag[w_gnt_idx];
                r_rsp_data <= w_gnt_data;
            end
        end
    end

    assign bus.notFull      = w_not_full;
    assign bus.rsp_en       = r_rsp_en;
    assign bus.rspTag       = r_rsp_tag;
    assign bus.rspData      = r_rsp_data;
    assign bus.nOutstanding = r_cnt;

    a_full: assert property (@(posedge clk) disable iff (!resetb) bus.req_en |-> w_not_full)
        else $fatal(1, "req_en asserted while no slot is free");
    a_dup: assert property (@(posedge clk) disable iff (!resetb) w_acc |-> !w_dup)
        else $fatal(1, "request tag already outstanding");
endmodule

// File: tb/tb_qa_drv_ooo_responder.sv
// tb_qa_drv_ooo_responder: randomized and directed checks of the responder against a
// deadline-based reference model (each request becomes ready at accept_edge+MIN_LAT+rnd).
module tb_qa_drv_ooo_responder;
    localparam int NE = 32, DW = 64, AW = 32, NS = 8, ML = 4, RL = 4;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    qa_drv_ooo_responder_if #(.N_ENTRIES(NE), .N_ADDR_BITS(AW), .N_DATA_BITS(DW), .N_SLOTS(NS)) bus ();

    qa_drv_ooo_responder #(
        .N_ENTRIES(NE), .N_DATA_BITS(DW), .N_ADDR_BITS(AW), .N_SLOTS(NS),
        .MIN_LAT(ML), .RND_LAT_BITS(RL), .LFSR_SEED(16'h1)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid [NS];
    logic [4:0]  m_tag   [NS];
    logic [31:0] m_addr  [NS];
    int          m_rdy   [NS];
    bit          busy    [NE];
    int          m_ptr, m_cnt, edge_n, n_req, n_rsp;
    logic [15:0] m_lfsr;
    bit          e_en;
    logic [4:0]  e_tag;
    logic [63:0] e_data;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < NE; i++) busy[i] = 1'b0;
        m_ptr = 0; m_cnt = 0; n_req = 0; n_rsp = 0;
        m_lfsr = 16'h1;
        e_en = 1'b0; e_tag = '0; e_data = '0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_rsp_en"}, 64'(bus.rsp_en), 0);
        chk({pfx, "_rspTag"}, 64'(bus.rspTag), 0);
        chk({pfx, "_rspData"}, bus.rspData, 0);
        chk({pfx, "_nOut"}, 64'(bus.nOutstanding), 0);
        chk({pfx, "_notFull"}, 64'(bus.notFull), 1);
    endtask

    // One clock: drive at negedge, predict this edge, compare just after it.
    task automatic step(input bit en, input logic [4:0] tag, input logic [31:0] addr);
        int g, f, j;
        bus.req_en = en; bus.reqTag = tag; bus.reqAddr = addr;
        g = -1; f = -1;
        for (int k = 1; k <= NS; k++) begin
            j = (m_ptr + k) % NS;
            if (g < 0 && m_valid[j] && edge_n >= m_rdy[j]) g = j;
        end
        if (en) for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) f = i;
        e_en = (g >= 0);
        if (g >= 0) begin
            e_tag = m_tag[g];
            e_data = {~m_addr[g], m_addr[g]};
            m_valid[g] = 1'b0; busy[m_tag[g]] = 1'b0; m_ptr = g; m_cnt--;
        end
        if (f >= 0) begin
            m_valid[f] = 1'b1; m_tag[f] = tag; m_addr[f] = addr;
            m_rdy[f] = edge_n + ML + int'(m_lfsr[RL-1:0]);
            m_lfsr = lfsr_step(m_lfsr);
            busy[tag] = 1'b1; m_cnt++; n_req++;
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (bus.rsp_en) n_rsp++;
        chk("rsp_en", 64'(bus.rsp_en), 64'(e_en));
        chk("rspTag", 64'(bus.rspTag), 64'(e_tag));
        chk("rspData", bus.rspData, e_data);
        chk("nOutstanding", 64'(bus.nOutstanding), 64'(m_cnt));
        chk("notFull", 64'(bus.notFull), 64'(m_cnt < NS));
        @(negedge clk);
    endtask

    task automatic rand_step(input int pct);
        int t;
        if (m_cnt < NS && $urandom_range(0, 99) < pct) begin
            t = $urandom_range(0, NE - 1);
            while (busy[t]) t = (t + 1) % NE;
            step(1'b1, 5'(t), $urandom);
        end else step(1'b0, '0, '0);
    endtask

    initial begin
        bus.req_en = 1'b0; bus.reqTag = '0; bus.reqAddr = '0;
        model_reset();
        edge_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        resetb = 1'b1;

        // Single request: seed 1 gives rnd=1, so response 5 edges after accept.
        step(1'b1, 5'd5, 32'h1000);
        repeat (5) step(1'b0, '0, '0);
        chk("t2_rsp_en", 64'(bus.rsp_en), 1);
        chk("t2_tag", 64'(bus.rspTag), 5);
        chk("t2_data", bus.rspData, 64'hFFFF_EFFF_0000_1000);
        repeat (3) step(1'b0, '0, '0);

        // Back-to-back burst of tags 0..7, then drain.
        for (int i = 0; i < NS; i++) step(1'b1, 5'(i), $urandom);
        for (int i = 0; i < 60 && m_cnt > 0; i++) step(1'b0, '0, '0);
        chk("burst_returned", 64'(n_rsp), 64'(n_req));

        // Heavy random traffic, keeps the pool full much of the time.
        for (int i = 0; i < 200; i++) rand_step(80);

        // Reset mid-traffic: asynchronous clear, in-flight requests discarded.
        resetb = 1'b0;
        #1;
        check_reset_outputs("rst1");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst1_hold");
        @(negedge clk);
        model_reset();
        resetb = 1'b1;
        repeat (25) step(1'b0, '0, '0);

        // Post-reset random traffic at mixed rates, then drain.
        for (int i = 0; i < 300; i++) rand_step(i < 150 ? 95 : 40);
        for (int i = 0; i < 100 && m_cnt > 0; i++) step(1'b0, '0, '0);
        chk("drain_nOut", 64'(bus.nOutstanding), 0);
        chk("all_returned", 64'(n_rsp), 64'(n_req));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
